// File: rtl/ccff_loader_pkg.sv
// Shared types and pass-geometry helpers for the CCFF chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Bitstream words needed to cover one full pass of the chain.
    function automatic int unsigned words_per_pass(input int unsigned chain_len,
                                                   input int unsigned data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

    // Bits actually used from the final word of a pass.
    function automatic int unsigned last_word_bits(input int unsigned chain_len,
                                                   input int unsigned data_w);
        int unsigned rem;
        rem = chain_len % data_w;
        return (rem == 0) ? data_w : rem;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the configuration port and the loader.
interface ccff_chain_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer feeding ccff_head; truncates the last word of each pass.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 19,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    ccff_chain_loader_if.slave  cfg,
    input  logic                active,
    input  logic                words_left,
    input  logic                last_word,
    input  logic                flush,
    output logic                ccff_head,
    output logic                prog_clk_en,
    output logic                word_accept_c
);

    localparam int unsigned CNT_W     = $clog2(DATA_W + 1);
    localparam int unsigned LAST_BITS = last_word_bits(CHAIN_LEN, DATA_W);
    localparam logic [DATA_W-1:0] LAST_MASK = ~({DATA_W{1'b1}} << LAST_BITS);

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  sr_cnt;

    assign prog_clk_en = active && (sr_cnt != '0);
    assign ccff_head   = sr[0];

    // Refill when empty, or as the last held bit shifts out, so words stream without a bubble.
    assign cfg.cfg_ready = active && words_left &&
                           ((sr_cnt == '0) || ((sr_cnt == CNT_W'(1)) && prog_clk_en));
    assign word_accept_c = cfg.cfg_ready && cfg.cfg_valid;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sr     <= '0;
            sr_cnt <= '0;
        end else if (flush) begin
            sr_cnt <= '0;
        end else if (word_accept_c) begin
            sr     <= last_word ? (cfg.cfg_data & LAST_MASK) : cfg.cfg_data;
            sr_cnt <= last_word ? CNT_W'(LAST_BITS) : CNT_W'(DATA_W);
        end else if (prog_clk_en) begin
            sr     <= sr >> 1;
            sr_cnt <= sr_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// CCFF chain controller: loads a bitstream pass and optionally verifies it on a second pass.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 19,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = $clog2(CHAIN_LEN)
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    input  logic                verify,
    input  logic                abort,
    ccff_chain_loader_if.slave  cfg,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                prog_clk_en,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [IDX_W-1:0]    first_err_idx
);

    localparam int unsigned WORDS = words_per_pass(CHAIN_LEN, DATA_W);
    localparam int unsigned WC_W  = $clog2(WORDS + 1);

    state_e            state;
    state_e            state_nxt;
    logic              verify_q;
    logic [IDX_W-1:0]  shift_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              active_c;
    logic              start_ok_c;
    logic              pass_end_c;
    logic              word_accept_c;

    assign active_c   = (state == LOAD) || (state == VERIFY);
    assign start_ok_c = start && !abort && (state == IDLE);
    assign pass_end_c = prog_clk_en && (shift_cnt == IDX_W'(CHAIN_LEN - 1));

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .DATA_W    (DATA_W)
    ) u_ser (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .cfg           (cfg),
        .active        (active_c),
        .words_left    (word_cnt != '0),
        .last_word     (word_cnt == WC_W'(1)),
        .flush         (abort),
        .ccff_head     (ccff_head),
        .prog_clk_en   (prog_clk_en),
        .word_accept_c (word_accept_c)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (pass_end_c) state_nxt = verify_q ? VERIFY : DONE;
                VERIFY:  if (pass_end_c) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-pass shift position and words still to fetch; both rearm for the read-back pass.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shift_cnt <= '0;
            word_cnt  <= '0;
            verify_q  <= 1'b0;
        end else if (abort) begin
            shift_cnt <= '0;
            word_cnt  <= '0;
        end else if (start_ok_c) begin
            shift_cnt <= '0;
            word_cnt  <= WC_W'(WORDS);
            verify_q  <= verify;
        end else begin
            if (prog_clk_en) begin
                shift_cnt <= pass_end_c ? '0 : shift_cnt + IDX_W'(1);
            end
            if (pass_end_c && (state == LOAD) && verify_q) begin
                word_cnt <= WC_W'(WORDS);
            end else if (word_accept_c) begin
                word_cnt <= word_cnt - WC_W'(1);
            end
        end
    end

    // The tail shows pass-1 bit k while pass-2 bit k is on the head.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            error         <= 1'b0;
            first_err_idx <= '0;
        end else if (start_ok_c) begin
            error         <= 1'b0;
            first_err_idx <= '0;
        end else if (!abort && (state == VERIFY) && prog_clk_en && !error &&
                     (ccff_tail != ccff_head)) begin
            error         <= 1'b1;
            first_err_idx <= shift_cnt;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader with a 19-bit chain model on ccff_head/ccff_tail.
module tb_ccff_chain_loader;

    localparam int unsigned CHAIN_LEN = 19;
    localparam int unsigned DATA_W    = 8;
    localparam logic [10:0] ALL       = 11'h7FF;

    logic       prog_clk     = 1'b0;
    logic       prog_reset_n = 1'b0;
    logic       start        = 1'b0;
    logic       verify       = 1'b0;
    logic       abort        = 1'b0;
    logic       ccff_head;
    logic       ccff_tail;
    logic       prog_clk_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] first_err_idx;

    ccff_chain_loader_if #(.DATA_W(DATA_W)) cfg_if ();

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .verify        (verify),
        .abort         (abort),
        .cfg           (cfg_if),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .prog_clk_en   (prog_clk_en),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .first_err_idx (first_err_idx)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Tile chain: shifts on enabled edges, not reset.
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge prog_clk) if (prog_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    assign ccff_tail = chain[CHAIN_LEN-1];

    typedef struct { int cyc; int k; logic b; } shift_t;
    typedef struct { int cyc; logic err; logic [4:0] idx; } done_t;
    typedef struct { string name; int cyc; logic [10:0] exp; logic [10:0] mask; } probe_t;

    shift_t head_q[$];
    int     acc_q[$];
    done_t  done_q[$];
    probe_t probe_q[$];

    int   n_cmp    = 0;
    int   n_bad    = 0;
    logic fin_req  = 1'b0;
    logic fin_done = 1'b0;

    // Monitor: pops expectations as the DUT presents shifts, accepts, done pulses and probes.
    always @(negedge prog_clk) begin
        shift_t      s;
        done_t       d;
        probe_t      p;
        int          c;
        logic [10:0] act;
        act = {busy, done, error, first_err_idx, cfg_if.cfg_ready, prog_clk_en, ccff_head};
        if (prog_clk_en) begin
            n_cmp++;
            if (head_q.size() == 0) begin
                n_bad++;
                $display("FAIL shift: unexpected shift at cycle %0d", cyc);
            end else begin
                s = head_q.pop_front();
                if (s.cyc != cyc || s.b !== ccff_head) begin
                    n_bad++;
                    $display("FAIL shift%0d: got cycle %0d head %0b, want cycle %0d head %0b",
                             s.k, cyc, ccff_head, s.cyc, s.b);
                end
            end
        end
        if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
            n_cmp++;
            if (acc_q.size() == 0) begin
                n_bad++;
                $display("FAIL accept: unexpected word accept at cycle %0d", cyc);
            end else begin
                c = acc_q.pop_front();
                if (c != cyc) begin
                    n_bad++;
                    $display("FAIL accept: got cycle %0d, want cycle %0d", cyc, c);
                end
            end
        end
        if (done) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL done: unexpected done at cycle %0d", cyc);
            end else begin
                d = done_q.pop_front();
                if (d.cyc != cyc || error !== d.err || (d.err && first_err_idx !== d.idx)) begin
                    n_bad++;
                    $display("FAIL done: got cycle %0d error %0b idx %0d, want cycle %0d error %0b idx %0d",
                             cyc, error, first_err_idx, d.cyc, d.err, d.idx);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            n_cmp++;
            if (p.cyc != cyc || ((act ^ p.exp) & p.mask) != '0) begin
                n_bad++;
                $display("FAIL %s: got %b at cycle %0d, want %b mask %b at cycle %0d",
                         p.name, act, cyc, p.exp, p.mask, p.cyc);
            end
        end
        if (fin_req && !fin_done) begin
            while (head_q.size() > 0) begin
                s = head_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL shift%0d: missing, want cycle %0d head %0b", s.k, s.cyc, s.b);
            end
            while (acc_q.size() > 0) begin
                c = acc_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL accept: missing, want cycle %0d", c);
            end
            while (done_q.size() > 0) begin
                d = done_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL done: missing, want cycle %0d", d.cyc);
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL %s: missing, want cycle %0d", p.name, p.cyc);
            end
            fin_done = 1'b1;
        end
    end

    task automatic push_pass(input int c0, input int base, input logic [18:0] bits,
                             input int n, input int gap_k, input int gap);
        for (int k = 0; k < n; k++) begin
            shift_t s;
            s.cyc = c0 + base + k + ((k >= gap_k) ? gap : 0);
            s.k   = k;
            s.b   = bits[k];
            head_q.push_back(s);
        end
    endtask

    task automatic push_done(input int c, input logic err, input logic [4:0] idx);
        done_t d;
        d.cyc = c; d.err = err; d.idx = idx;
        done_q.push_back(d);
    endtask

    task automatic push_probe(input string name, input int c, input logic [10:0] e,
                              input logic [10:0] m);
        probe_t p;
        p.name = name; p.cyc = c; p.exp = e; p.mask = m;
        probe_q.push_back(p);
    endtask

    task automatic send_words(input logic [7:0] w [6], input int n, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            cfg_if.cfg_data  = w[i];
            cfg_if.cfg_valid = 1'b1;
            t = 0;
            @(negedge prog_clk);
            while (!cfg_if.cfg_ready && t < 300) begin
                @(negedge prog_clk);
                t++;
            end
            @(posedge prog_clk); #1;
            if (i == 0 && gap > 0) begin
                cfg_if.cfg_valid = 1'b0;
                t = 0;
                @(negedge prog_clk);
                while (!cfg_if.cfg_ready && t < 300) begin
                    @(negedge prog_clk);
                    t++;
                end
                repeat (gap) @(posedge prog_clk);
                #1;
            end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic start_load(input logic v, output int c0);
        @(posedge prog_clk); #1;
        c0     = cyc;
        start  = 1'b1;
        verify = v;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge prog_clk);
        while (busy && t < 400) begin
            @(negedge prog_clk);
            t++;
        end
        @(posedge prog_clk); #1;
    endtask

    initial begin
        logic [7:0] w [6];
        int c0;
        cfg_if.cfg_data  = '0;
        cfg_if.cfg_valid = 1'b0;

        push_probe("reset_values", 2, 11'h000, ALL);
        repeat (3) @(posedge prog_clk);
        #1 prog_reset_n = 1'b1;
        push_probe("idle_after_reset", cyc + 1, 11'h000, ALL);
        @(posedge prog_clk); #1;

        // Plain load: 0xA5, 0x3C, 0x05 streamed back to back.
        w = '{8'hA5, 8'h3C, 8'h05, 8'h00, 8'h00, 8'h00};
        fork
            send_words(w, 3, 0);
            begin
                start_load(1'b0, c0);
                acc_q.push_back(c0 + 1); acc_q.push_back(c0 + 9); acc_q.push_back(c0 + 17);
                push_pass(c0, 2, 19'h53CA5, 19, 99, 0);
                push_done(c0 + 21, 1'b0, 5'd0);
                wait_idle();
            end
        join

        // Load plus clean read-back.
        w = '{8'hA5, 8'h3C, 8'h05, 8'hA5, 8'h3C, 8'h05};
        fork
            send_words(w, 6, 0);
            begin
                start_load(1'b1, c0);
                acc_q.push_back(c0 + 1);  acc_q.push_back(c0 + 9);  acc_q.push_back(c0 + 17);
                acc_q.push_back(c0 + 21); acc_q.push_back(c0 + 29); acc_q.push_back(c0 + 37);
                push_pass(c0, 2, 19'h53CA5, 19, 99, 0);
                push_pass(c0, 22, 19'h53CA5, 19, 99, 0);
                push_done(c0 + 41, 1'b0, 5'd0);
                wait_idle();
            end
        join

        // Read-back with bits 10 and 15 flipped: first index 10 must stick.
        w = '{8'hA5, 8'h3C, 8'h05, 8'hA5, 8'hB8, 8'h05};
        fork
            send_words(w, 6, 0);
            begin
                start_load(1'b1, c0);
                acc_q.push_back(c0 + 1);  acc_q.push_back(c0 + 9);  acc_q.push_back(c0 + 17);
                acc_q.push_back(c0 + 21); acc_q.push_back(c0 + 29); acc_q.push_back(c0 + 37);
                push_pass(c0, 2, 19'h53CA5, 19, 99, 0);
                push_pass(c0, 22, 19'h5B8A5, 19, 99, 0);
                push_done(c0 + 41, 1'b1, 5'd10);
                wait_idle();
                push_probe("error_sticky", cyc, 11'h150, 11'h1F8);
            end
        join

        // Five-cycle valid stall between words 1 and 2; start also clears the error.
        w = '{8'hA5, 8'h3C, 8'h05, 8'h00, 8'h00, 8'h00};
        fork
            send_words(w, 3, 5);
            begin
                start_load(1'b0, c0);
                acc_q.push_back(c0 + 1); acc_q.push_back(c0 + 14); acc_q.push_back(c0 + 22);
                push_pass(c0, 2, 19'h53CA5, 19, 8, 5);
                push_done(c0 + 26, 1'b0, 5'd0);
                wait_idle();
            end
        join

        // Asynchronous reset during shift 7.
        fork
            send_words(w, 1, 0);
            begin
                start_load(1'b0, c0);
                acc_q.push_back(c0 + 1);
                push_pass(c0, 2, 19'h53CA5, 7, 99, 0);
                repeat (8) @(posedge prog_clk);
                #1;
                push_probe("reset_mid_pass", c0 + 9, 11'h000, ALL);
                prog_reset_n = 1'b0;
                @(posedge prog_clk); #1;
                prog_reset_n = 1'b1;
                push_probe("idle_after_mid_reset", cyc, 11'h000, ALL);
                @(posedge prog_clk); #1;
            end
        join

        // Fresh load after reset, with a start+verify pulse while busy that must be ignored.
        fork
            send_words(w, 3, 0);
            begin
                start_load(1'b0, c0);
                acc_q.push_back(c0 + 1); acc_q.push_back(c0 + 9); acc_q.push_back(c0 + 17);
                push_pass(c0, 2, 19'h53CA5, 19, 99, 0);
                push_done(c0 + 21, 1'b0, 5'd0);
                repeat (4) @(posedge prog_clk);
                #1;
                start  = 1'b1;
                verify = 1'b1;
                @(posedge prog_clk); #1;
                start  = 1'b0;
                verify = 1'b0;
                wait_idle();
            end
        join

        // Abort during shift 4: idle next cycle, no done.
        fork
            send_words(w, 1, 0);
            begin
                start_load(1'b0, c0);
                acc_q.push_back(c0 + 1);
                push_pass(c0, 2, 19'h53CA5, 5, 99, 0);
                repeat (5) @(posedge prog_clk);
                #1 abort = 1'b1;
                @(posedge prog_clk); #1;
                abort = 1'b0;
                push_probe("abort_next_cycle", c0 + 7, 11'h000, 11'h606);
                repeat (6) @(posedge prog_clk);
                #1;
            end
        join

        // Abort wins over a simultaneous start.
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        push_probe("start_abort_same_cycle", cyc, 11'h000, 11'h406);
        repeat (3) @(posedge prog_clk);
        #1;

        fin_req = 1'b1;
        repeat (3) @(posedge prog_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched",
                 n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain controller for the fracturable logic tile's configuration flip-flop (CCFF) chain. It accepts a bitstream as words over a valid/ready handshake and serializes it onto `ccff_head`. It produces the clock-gate enable that advances the chain exactly `CHAIN_LEN` positions per pass. It can optionally run a second read-back pass that compares `ccff_tail` against the re-supplied bitstream. It sits between the configuration port and the tile's `ccff_head`/`ccff_tail` and `prog_clk` gate.

## Interface
- `CHAIN_LEN`, default 19: number of CCFF bits in the controlled chain (frac_lut4 plus output mux memory); must be ≥ 2.
- `DATA_W`, default 8: bitstream word width; must be ≥ 1.
- `IDX_W`, default `$clog2(CHAIN_LEN)`: width of the bit index.

One clock, `prog_clk`. Reset `prog_reset_n` is asynchronous and active-low.
- `prog_clk`  in  1  controller clock; ungated.
- `prog_reset_n`  in  1  async active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `verify`  in  1  sampled with `start`; 1 adds a read-back pass.
- `abort`  in  1  forces return to IDLE.
- `cfg_data`  in  DATA_W  bitstream word; bit 0 is shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  controller accepts the word on this edge.
- `ccff_head`  out  1  serial bit into the chain.
- `ccff_tail`  in  1  serial bit out of the chain.
- `prog_clk_en`  out  1  chain clock-gate enable; the chain shifts on each `prog_clk` edge where this is 1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of the sequence.
- `error`  out  1  sticky verify mismatch; cleared by an accepted `start`.
- `first_err_idx`  out  IDX_W  bit index of the first mismatch; valid while `error` = 1.

## Operation
- States:
  - IDLE → LOAD on `start`.
  - LOAD → VERIFY, if `verify` was latched, after `CHAIN_LEN` shifts.
  - LOAD → DONE after `CHAIN_LEN` shifts when `verify` is not latched.
  - VERIFY → DONE after `CHAIN_LEN` shifts.
  - DONE → IDLE unconditionally after one cycle.
- Serializer: holds `sr` (DATA_W bits) and `sr_cnt` (valid bits remaining).
- Bit presentation: `ccff_head` = `sr[0]` and `prog_clk_en` = 1 iff `sr_cnt` > 0 and the state is LOAD or VERIFY. Each such edge is one shift: `sr` shifts right, `sr_cnt` decrements, `shift_cnt` increments.
- Words per pass = ceil(`CHAIN_LEN`/`DATA_W`). On the last word only `CHAIN_LEN` mod `DATA_W` low bits are used (all bits if that remainder is 0); the rest are discarded.
- `cfg_ready` = (LOAD or VERIFY) and words remaining in the pass > 0 and (`sr_cnt` == 0 or (`sr_cnt` == 1 and `prog_clk_en`)). This gives back-to-back words with no bubble.
- When `cfg_valid` is low and `sr_cnt` == 0: `prog_clk_en` = 0 and the chain holds.
- Pass 2 compare: on each shift in VERIFY, compare `ccff_tail` with `ccff_head`. This is exact because the tail shows pass-1 bit k during pass-2 shift k.
- On the first mismatch: set `error` and latch `shift_cnt` into `first_err_idx`. Later mismatches do not update it.
- `start` while busy is ignored.
- `abort` in any state: next state IDLE, `prog_clk_en` = 0, `sr_cnt` cleared, no `done`, `error` unchanged. The chain contents are then undefined.
- `abort` and `start` in the same cycle: `abort` wins.

## Timing
- Reset values: state IDLE, `cfg_ready` 0, `ccff_head` 0, `prog_clk_en` 0, `busy` 0, `done` 0, `error` 0, `first_err_idx` 0, all counters 0.
- Reset asserted mid-pass gives the same values immediately (asynchronous).
- `start` on edge 0 → LOAD from cycle 1.
- A word accepted on the edge ending cycle t drives its bit 0 on `ccff_head` in cycle t+1.
- Sustained valid gives 1 bit/cycle.
- A LOAD-to-VERIFY transition inserts exactly one bubble cycle (`sr` empty).
- `done` is high in the cycle after the final shift. `busy` falls the cycle after `done`.
- All outputs are registered except `cfg_ready`, `prog_clk_en` and `ccff_head`, which are combinational from flops only.

## Structure
- Package `ccff_loader_pkg` holds the state enum (IDLE, LOAD, VERIFY, DONE) and helper functions for the words-per-pass and last-word-bits constants.
- Sub-module `ccff_word_serializer` owns `sr`/`sr_cnt`, the last-word truncation and `cfg_ready` generation.
- The top level owns the FSM, `shift_cnt`, the word counter and the compare/error logic.

## Test plan
- Load, `CHAIN_LEN`=19, `DATA_W`=8, `verify`=0, words 0xA5, 0x3C, 0x05 with continuous valid, `start` at cycle 0:
  - `cfg_ready` high in cycles 1, 9 and 17.
  - Exactly 19 `prog_clk_en` cycles, in cycles 2–20.
  - Head sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,0,1.
  - `done` in cycle 21.
- Verify pass with the same 3 words resupplied: 38 shifts total, `done` in cycle 41, `error` = 0.
- Verify pass with bit 10 flipped in pass 2: `error` = 1 and `first_err_idx` = 10. A second flip at bit 15 leaves the index at 10.
- Stall with `cfg_valid` low for 5 cycles between words 1 and 2: `prog_clk_en` low for those cycles, total shifts still 19, `done` delayed by 5 cycles.
- `prog_reset_n` pulsed at shift 7: all outputs return to reset values the same cycle. A new `start` then loads correctly.
- `start` while busy is ignored. `abort` at shift 4 → IDLE next cycle, no `done`, `prog_clk_en` 0.
